// File: rtl/branch_issue_if.sv
// Control-flow, instruction-ROM and issue-slot signals between branch_issue and its neighbours.
// The master side belongs to branch_issue, the producer of goto/call/ret/skip and the issue slot.
interface branch_issue_if #(
  parameter int IW = 16,
  parameter int AW = 12
);
  logic          pause;
  logic [AW-1:0] pc;
  logic          kill;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          flag_we;
  logic          flag_in;
  logic          goto;
  logic [AW-1:0] goto_addr;
  logic          call;
  logic          ret;
  logic          skip;
  logic          issue_valid;
  logic [IW-1:0] issue_instr;
  logic [AW-1:0] issue_pc;
  logic          illegal;

  modport master (
    input  pause, pc, kill, imem_data, flag_we, flag_in,
    output imem_addr, goto, goto_addr, call, ret, skip,
           issue_valid, issue_instr, issue_pc, illegal
  );

  modport slave (
    output pause, pc, kill, imem_data, flag_we, flag_in,
    input  imem_addr, goto, goto_addr, call, ret, skip,
           issue_valid, issue_instr, issue_pc, illegal
  );
endinterface

// File: rtl/branch_issue.sv
// Fetch/decode front end: decodes control-flow opcodes back to the PC controller and
// registers ordinary instructions into the issue slot, holding the fetched word across pauses.
module branch_issue #(
  parameter int IW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  branch_issue_if.master bus
);

  localparam logic [3:0] OP_GOTO = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_SKZ  = 4'hB;
  localparam logic [3:0] OP_SKNZ = 4'hC;
  localparam logic [3:0] OP_ALUD = 4'hD;

  logic          fetch_valid_q, fetch_valid_d;
  logic          hold_valid_q,  hold_valid_d;
  logic [IW-1:0] hold_q,        hold_d;
  logic          zflag_q,       zflag_d;
  logic          issue_valid_q, issue_valid_d;
  logic [IW-1:0] issue_instr_q, issue_instr_d;
  logic [AW-1:0] issue_pc_q,    issue_pc_d;
  logic          illegal_q,     illegal_d;

  logic [IW-1:0] word;
  logic [3:0]    opcode;
  logic          live;
  logic          ordinary;
  logic          reserved;
  logic          zflag_eff;
  logic [AW-1:0] word_pc;

  assign bus.imem_addr = bus.pc;

  // The ROM output moves on while pc is frozen, so a paused word comes from the hold register.
  always_comb begin
    word      = hold_valid_q ? hold_q : bus.imem_data;
    opcode    = word[IW-1 -: 4];
    live      = fetch_valid_q && !bus.kill && !bus.pause;
    ordinary  = !opcode[3] || (opcode == OP_ALUD);
    reserved  = (opcode >= 4'hE);
    zflag_eff = bus.flag_we ? bus.flag_in : zflag_q;
    word_pc   = bus.pc - AW'(1);
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    bus.goto      = 1'b0;
    bus.goto_addr = '0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.skip      = 1'b0;
    if (live) begin
      bus.goto_addr = word[AW-1:0];
      case (opcode)
        OP_GOTO: bus.goto = 1'b1;
        OP_CALL: begin
          bus.goto = 1'b1;
          bus.call = 1'b1;
        end
        OP_RET:  bus.ret  = 1'b1;
        OP_SKZ:  bus.skip = zflag_eff;
        OP_SKNZ: bus.skip = !zflag_eff;
        default: ;
      endcase
    end
  end

  always_comb begin
    fetch_valid_d = 1'b1;
    zflag_d       = zflag_eff;
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    issue_valid_d = issue_valid_q;
    issue_instr_d = issue_instr_q;
    issue_pc_d    = issue_pc_q;
    illegal_d     = illegal_q || (live && reserved);

    if (bus.pause) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_d       = bus.imem_data;
      end
    end else begin
      hold_valid_d  = 1'b0;
      issue_valid_d = live && ordinary;
      if (live && ordinary) begin
        issue_instr_d = word;
        issue_pc_d    = word_pc;
      end
    end
  end

  // NOTE: the hold data register is reset too, so nothing from before a reset survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
      zflag_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      issue_pc_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      fetch_valid_q <= fetch_valid_d;
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
      zflag_q       <= zflag_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_pc_q    <= issue_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_instr = issue_instr_q;
  assign bus.issue_pc    = issue_pc_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_branch_issue.sv
// Bench for branch_issue: directed scenarios with literal expectations, then randomized
// stimulus checked every cycle against a behavioural model of the fetch/decode rules.
module tb_branch_issue;
  localparam int IW = 16;
  localparam int AW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  branch_issue_if #(.IW(IW), .AW(AW)) bus ();

  branch_issue #(.IW(IW), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the word under decode, its liveness, and the architectural state.
  bit          m_fetched   = 1'b0;
  bit          m_held      = 1'b0;
  logic [15:0] m_hold_word = '0;
  bit          m_zflag     = 1'b0;
  bit          m_iv        = 1'b0;
  logic [15:0] m_ii        = '0;
  logic [11:0] m_ipc       = '0;
  bit          m_illegal   = 1'b0;

  typedef struct packed {
    logic        goto;
    logic [11:0] goto_addr;
    logic        call;
    logic        ret;
    logic        skip;
  } ctrl_t;

  function automatic logic [15:0] cur_word();
    return m_held ? m_hold_word : bus.imem_data;
  endfunction

  function automatic bit cur_live();
    return m_fetched && !bus.kill && !bus.pause;
  endfunction

  function automatic ctrl_t model_ctrl();
    ctrl_t       c;
    logic [15:0] w;
    logic [3:0]  op;
    bit          z;
    c  = '0;
    w  = cur_word();
    op = w[15:12];
    z  = bus.flag_we ? bus.flag_in : m_zflag;
    if (cur_live()) begin
      c.goto_addr = w[11:0];
      c.goto      = (op == 4'd8) || (op == 4'd9);
      c.call      = (op == 4'd9);
      c.ret       = (op == 4'd10);
      if (op == 4'd11) c.skip = z;
      if (op == 4'd12) c.skip = !z;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_fetched = 0; m_held = 0; m_hold_word = '0; m_zflag = 0;
    m_iv = 0; m_ii = '0; m_ipc = '0; m_illegal = 0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    logic [3:0]  op;
    bit          live;
    w    = cur_word();
    op   = w[15:12];
    live = cur_live();
    if (bus.flag_we) m_zflag = bus.flag_in;
    if (!bus.pause) begin
      m_iv = live && ((op < 4'd8) || (op == 4'd13));
      if (m_iv) begin
        m_ii  = w;
        m_ipc = bus.pc - 12'd1;
      end
    end
    if (live && (op >= 4'd14)) m_illegal = 1;
    if (bus.pause) begin
      if (!m_held) begin
        m_hold_word = bus.imem_data;
        m_held      = 1;
      end
    end else begin
      m_held = 0;
    end
    m_fetched = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_edge();
  end

  // Single compare process: every output against the model, every cycle, away from the edge.
  initial forever begin
    ctrl_t e;
    @(negedge clk);
    e = model_ctrl();
    check("imem_addr",   32'(bus.imem_addr),   32'(bus.pc));
    check("goto",        32'(bus.goto),        32'(e.goto));
    check("goto_addr",   32'(bus.goto_addr),   32'(e.goto_addr));
    check("call",        32'(bus.call),        32'(e.call));
    check("ret",         32'(bus.ret),         32'(e.ret));
    check("skip",        32'(bus.skip),        32'(e.skip));
    check("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
    check("issue_instr", 32'(bus.issue_instr), 32'(m_ii));
    check("issue_pc",    32'(bus.issue_pc),    32'(m_ipc));
    check("illegal",     32'(bus.illegal),     32'(m_illegal));
  end

  // Inputs change just after the rising edge; the task returns just after the falling edge.
  task automatic step(input bit p, input logic [11:0] pc, input bit k,
                      input logic [15:0] d, input bit fwe, input bit fin);
    @(posedge clk);
    #1;
    bus.pause     = p;
    bus.pc        = pc;
    bus.kill      = k;
    bus.imem_data = d;
    bus.flag_we   = fwe;
    bus.flag_in   = fin;
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_iv"},   32'(bus.issue_valid), 32'd0);
    check({tag, "_ii"},   32'(bus.issue_instr), 32'd0);
    check({tag, "_ipc"},  32'(bus.issue_pc),    32'd0);
    check({tag, "_ill"},  32'(bus.illegal),     32'd0);
    check({tag, "_goto"}, 32'(bus.goto),        32'd0);
  endtask

  logic [11:0] pc_r;

  initial begin
    bus.pause = 0; bus.pc = '0; bus.kill = 0;
    bus.imem_data = '0; bus.flag_we = 0; bus.flag_in = 0;
    #2 rst_n = 1'b0;

    // Reset release: the first word is never live, the next GOTO is.
    step(0, 12'd0, 0, 16'h8005, 0, 0);
    check_all_zero("rst");
    #2 rst_n = 1'b1;
    #1 check("first_goto", 32'(bus.goto), 32'd0);
    step(0, 12'd1, 0, 16'h8005, 0, 0);
    check("goto5",      32'(bus.goto),      32'd1);
    check("goto5_addr", 32'(bus.goto_addr), 32'h005);
    step(0, 12'd2, 1, 16'h0000, 0, 0);
    check("goto_no_iss", 32'(bus.issue_valid), 32'd0);
    check("kill_goto",   32'(bus.goto),        32'd0);

    // CALL, then the same word killed.
    step(0, 12'd4, 0, 16'h9123, 0, 0);
    check("call_goto", 32'(bus.goto),      32'd1);
    check("call_call", 32'(bus.call),      32'd1);
    check("call_addr", 32'(bus.goto_addr), 32'h123);
    step(0, 12'd5, 1, 16'h9123, 0, 0);
    check("kcall_ctrl", 32'({bus.goto, bus.call, bus.ret, bus.skip}), 32'd0);
    check("kcall_addr", 32'(bus.goto_addr),   32'd0);
    check("call_no_iss", 32'(bus.issue_valid), 32'd0);

    // Zero-flag bypass for SKZ / SKNZ.
    step(0, 12'd6, 0, 16'h0000, 1, 0);
    step(0, 12'd7, 0, 16'hB000, 1, 1);
    check("skz_bypass", 32'(bus.skip), 32'd1);
    step(0, 12'd8, 0, 16'hB000, 0, 0);
    check("skz_reg", 32'(bus.skip), 32'd1);
    step(0, 12'd9, 0, 16'h0000, 1, 0);
    step(0, 12'd10, 0, 16'hC000, 1, 1);
    check("sknz_bypass", 32'(bus.skip), 32'd0);
    step(0, 12'd11, 0, 16'hC000, 0, 0);
    check("sknz_reg", 32'(bus.skip), 32'd0);

    // Three-cycle pause over 0x1234 at address 7 while the ROM output changes.
    step(0, 12'd7, 0, 16'h0042, 0, 0);
    step(1, 12'd8, 0, 16'h1234, 0, 0);
    check("pz_iv", 32'(bus.issue_valid), 32'd1);
    check("pz_ii", 32'(bus.issue_instr), 32'h0042);
    check("pz_ipc", 32'(bus.issue_pc),   32'h006);
    for (int i = 0; i < 2; i++) begin
      step(1, 12'd8, 0, 16'hFFFF, 0, 0);
      check("pz_hold_iv", 32'(bus.issue_valid), 32'd1);
      check("pz_hold_ii", 32'(bus.issue_instr), 32'h0042);
    end
    step(0, 12'd8, 0, 16'hFFFF, 0, 0);
    check("pz_word_goto", 32'(bus.goto), 32'd0);
    step(0, 12'd9, 0, 16'hE000, 0, 0);
    check("pz_out_iv",  32'(bus.issue_valid), 32'd1);
    check("pz_out_ii",  32'(bus.issue_instr), 32'h1234);
    check("pz_out_ipc", 32'(bus.issue_pc),    32'h007);
    check("pz_out_ill", 32'(bus.illegal),     32'd0);

    // Reserved opcode is sticky and not issued; decode continues.
    step(0, 12'd10, 0, 16'h0001, 0, 0);
    check("ill_set",    32'(bus.illegal),     32'd1);
    check("ill_no_iss", 32'(bus.issue_valid), 32'd0);
    step(0, 12'd11, 0, 16'h0000, 0, 0);
    check("ill_next_iv",  32'(bus.issue_valid), 32'd1);
    check("ill_next_ii",  32'(bus.issue_instr), 32'h0001);
    check("ill_next_ipc", 32'(bus.issue_pc),    32'h009);
    check("ill_sticky",   32'(bus.illegal),     32'd1);

    // Asynchronous reset in the middle of a pause discards the hold register.
    step(1, 12'd12, 0, 16'h8007, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    step(0, 12'd12, 0, 16'h8009, 0, 0);
    #2 rst_n = 1'b1;
    #1 check("arst_first", 32'(bus.goto), 32'd0);
    step(0, 12'd13, 0, 16'h800A, 0, 0);
    check("arst_goto", 32'(bus.goto),      32'd1);
    check("arst_addr", 32'(bus.goto_addr), 32'h00A);

    // Randomized traffic, with occasional asynchronous reset pulses.
    pc_r = 12'd14;
    for (int i = 0; i < 3000; i++) begin
      bit p, k, fwe, fin;
      logic [15:0] d;
      p   = ($urandom_range(0, 3) == 0);
      k   = ($urandom_range(0, 4) == 0);
      fwe = ($urandom_range(0, 2) == 0);
      fin = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      if ($urandom_range(0, 15) == 0) d[15:12] = 4'hE + 4'($urandom_range(0, 1));
      else if (d[15:12] >= 4'hE)      d[15:12] = 4'($urandom_range(0, 13));
      if ($urandom_range(0, 19) == 0) pc_r = 12'($urandom);
      else if (!p)                    pc_r = pc_r + 12'd1;
      step(p, pc_r, k, d, fwe, fin);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_issue.md
Name: branch_issue

Overview:
- Fetch/decode front end on the instruction side of the PC controller.
- Takes the program counter and kill flag from the PC controller and the synchronous instruction-ROM word.
- Decodes control-flow opcodes and drives goto/goto_addr/call/ret/skip back to the PC controller.
- Registers non-control instructions into the issue slot for the execute stage. It is the producer end of the PC controller's control-flow interface.

Parameters:
- IW, 16, instruction word width.
- AW, 12, program address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pause  in  1  global stall; same signal the PC controller receives
- pc  in  AW  current PC from the PC controller; also the ROM read address
- kill  in  1  PC controller kill flag; the word at the ROM output is squashed
- imem_addr  out  AW  ROM address, equal to pc
- imem_data  in  IW  ROM read data, valid one cycle after the address
- flag_we  in  1  execute stage writes the zero flag this cycle
- flag_in  in  1  new zero-flag value
- goto  out  1  jump request
- goto_addr  out  AW  jump target
- call  out  1  qualifies goto as a call
- ret  out  1  return request
- skip  out  1  squash the next instruction
- issue_valid  out  1  issue slot holds a live instruction
- issue_instr  out  IW  issued instruction
- issue_pc  out  AW  address of the issued instruction
- illegal  out  1  sticky reserved-opcode error

Behaviour:
- Reset is asynchronous, asserted while reset=0.
- Reset values:
  - issue_valid=0, issue_instr=0, issue_pc=0, illegal=0.
  - Internal zflag=0, fetch_valid=0, hold_valid=0.
- fetch_valid is set on the first clock edge after reset release. It marks that the ROM output holds a real fetch.
- Current word W:
  - W = hold register when hold_valid=1, otherwise imem_data.
  - W is live when fetch_valid=1, kill=0 and pause=0.
- Current address: W's address = pc-1 (mod 2^AW). While paused, pc is frozen, so the address is unchanged.
- Pause hold:
  - First paused cycle with hold_valid=0: latch imem_data and set hold_valid=1.
  - hold_valid clears on the first edge with pause=0.
  - W stays stable across a pause of any length.
- Decode uses W[15:12]; all outputs below are combinational, gated by live, and 0 otherwise.
  - 8 GOTO: goto=1, goto_addr=W[11:0].
  - 9 CALL: goto=1, call=1, goto_addr=W[11:0].
  - A RET: ret=1.
  - B SKZ: skip = effective zflag.
  - C SKNZ: skip = NOT effective zflag.
  - E, F: reserved.
  - 0-7, D: ordinary instructions.
  - goto_addr = W[11:0] whenever live, so it is stable for the PC controller.
- Effective zflag = flag_in if flag_we=1, else the zflag register.
  - zflag <= flag_in on any edge with flag_we=1, independent of pause.
- Issue slot, updated on each edge with pause=0:
  - issue_valid <= live AND ordinary opcode.
  - issue_instr <= W and issue_pc <= pc-1 only when that issue_valid term is 1.
  - When the term is 0, issue_instr and issue_pc hold.
- Issue slot while paused: all issue registers hold.
- Control opcodes are never issued; control flow costs no execute slot.
- Reserved opcode while live: illegal <= 1 (sticky until reset) and the word is not issued. Decode continues after the error.
- kill=1 squashes all decode outputs and the issue for that word. This covers both kill cycles after a goto and the single kill after a skip.
- Latency: word at address A reaches imem_data when pc=A+1. Control outputs appear that cycle, and the issue register updates at the end of that cycle.
- Reset mid-pause discards the hold register. The first word after reset release is never live.

Test Plan:
- Reset release with pc=0 and ROM[0]=0x8005 (GOTO 5): goto stays 0 in the first cycle, because fetch_valid is not yet set. In the next cycle, goto=1 and goto_addr=0x005, with no issue.
- ROM[3]=0x9123 fetched with pc=4, kill=0: goto=1, call=1, goto_addr=0x123, issue_valid=0 next cycle. With kill=1 on the same word: all control outputs are 0.
- zflag=0, then flag_we=1 and flag_in=1 in the same cycle an SKZ (0xB000) is live: skip=1 that cycle, and zflag reads 1 afterwards. SKNZ in the same situation gives skip=0.
- Ordinary 0x1234 at address 7 with pause=1 for 3 cycles while the ROM output changes to 0xFFFF: W stays 0x1234 and issue_valid holds. After pause drops: issue_instr=0x1234, issue_pc=0x007, illegal=0.
- Live 0xE000: illegal=1, no issue. A following 0x0001 is issued normally, and illegal stays 1 until reset.
- reset asserted asynchronously mid-cycle during a pause: all outputs go to 0 immediately without a clock edge, and hold_valid=0.
